// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS core.
// Steps the shared ALU, register file, PC and unified memory through the
// fetch/decode/execute/memory/writeback states. It also produces the 4-bit
// ALU control code directly, decoding funct for R-type instructions.
// Optional build macro: MIPS_CTRL_PERF_EN adds the cycle_cnt and instr_cnt
// performance counter outputs.
module mips_multicycle_ctrl #(
    parameter int FUNCT_W      = 6,
    parameter int RESULT_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              opcode,
    input  logic [FUNCT_W-1:0]      funct,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    i_or_d,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [3:0]              alu_ctrl,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    illegal_instr,
`ifdef MIPS_CTRL_PERF_EN
    output logic [RESULT_CNT_W-1:0] cycle_cnt,
    output logic [RESULT_CNT_W-1:0] instr_cnt,
`endif
    output logic [3:0]              state_o
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // State-decoded control bundle, registered together with the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_XOR = 4'd13;

    // True for the R-type funct codes this core implements
    function automatic logic f_funct_ok(input logic [FUNCT_W-1:0] fn);
        logic ok;
        ok = 1'b0;
        if (fn == FUNCT_W'(6'h20) || fn == FUNCT_W'(6'h22) ||
            fn == FUNCT_W'(6'h24) || fn == FUNCT_W'(6'h25) ||
            fn == FUNCT_W'(6'h26) || fn == FUNCT_W'(6'h27) ||
            fn == FUNCT_W'(6'h2A))
            ok = 1'b1;
        return ok;
    endfunction

    // R-type funct to ALU code; unknown funct falls back to ADD
    function automatic logic [3:0] f_alu_r(input logic [FUNCT_W-1:0] fn);
        logic [3:0] a;
        a = ALU_ADD;
        if (fn == FUNCT_W'(6'h22)) a = ALU_SUB;
        if (fn == FUNCT_W'(6'h24)) a = ALU_AND;
        if (fn == FUNCT_W'(6'h25)) a = ALU_OR;
        if (fn == FUNCT_W'(6'h26)) a = ALU_XOR;
        if (fn == FUNCT_W'(6'h27)) a = ALU_NOR;
        if (fn == FUNCT_W'(6'h2A)) a = ALU_SLT;
        return a;
    endfunction

    // Next-state function; mem_ready only matters in the memory-wait states
    function automatic state_t f_next(input state_t s, input logic [5:0] op,
                                      input logic [FUNCT_W-1:0] fn, input logic rdy);
        state_t n;
        n = S_RST;
        case (s)
            S_RST:    n = S_FETCH;
            S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   n = S_MEMADR;
                    OP_RTYPE:       n = S_EXEC;
                    OP_ADDI:        n = S_ADDIEX;
                    OP_BEQ, OP_BNE: n = S_BRANCH;
                    OP_J:           n = S_JUMP;
                    default:        n = S_TRAP;
                endcase
            end
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  n = S_FETCH;
            S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   n = f_funct_ok(fn) ? S_ALUWB : S_TRAP;
            S_ALUWB:  n = S_FETCH;
            S_ADDIEX: n = S_ADDIWB;
            S_ADDIWB: n = S_FETCH;
            S_BRANCH: n = S_FETCH;
            S_JUMP:   n = S_FETCH;
            S_TRAP:   n = S_TRAP;
            default:  n = S_RST;
        endcase
        return n;
    endfunction

    // Control bundle for a given state; anything not listed stays 0
    function automatic ctrl_t f_ctrl(input state_t s, input logic [FUNCT_W-1:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = ALU_ADD; end
            S_DECODE: begin c.alu_src_b = 2'b11; c.alu_ctrl = ALU_ADD; end
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = ALU_ADD; end
            S_MEMRD:  begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_ctrl = f_alu_r(fn); end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = ALU_ADD; end
            S_ADDIWB: begin c.reg_write = 1'b1; end
            S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_ctrl = ALU_SUB; c.pc_src = 2'b01; end
            S_JUMP:   begin c.pc_src = 2'b10; end
            S_TRAP:   begin c.illegal = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_br_take;

    // Next state from current state and IR fields
    always_comb begin
        w_next = f_next(r_state, opcode, funct, mem_ready);
    end

    // State register; the control bundle is decoded from the next state so
    // outputs are registered yet always reflect the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next, funct);
        end
    end

    // Branch condition: BNE inverts the ALU zero flag
    always_comb begin
        w_br_take = (opcode == OP_BNE) ? ~zero : zero;
    end

    assign mem_req       = r_ctrl.mem_req;
    assign mem_we        = r_ctrl.mem_we;
    assign i_or_d        = r_ctrl.i_or_d;
    assign pc_src        = r_ctrl.pc_src;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign alu_ctrl      = r_ctrl.alu_ctrl;
    assign reg_write     = r_ctrl.reg_write;
    assign reg_dst       = r_ctrl.reg_dst;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign illegal_instr = r_ctrl.illegal;
    assign state_o       = r_state;

    // The fetch completion and taken branch are qualified by live inputs
    assign ir_write = (r_state == S_FETCH) & mem_ready;
    assign pc_write = ((r_state == S_FETCH) & mem_ready) |
                      ((r_state == S_BRANCH) & w_br_take) |
                      (r_state == S_JUMP);

`ifdef MIPS_CTRL_PERF_EN
    logic [RESULT_CNT_W-1:0] r_cycle_cnt;
    logic [RESULT_CNT_W-1:0] r_instr_cnt;

    // Active-cycle and retired-instruction counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_RST && r_state != S_TRAP)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_RST)
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    logic [RESULT_CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sequences the shared ALU, register file, PC and unified memory through fetch, decode, execute, memory and writeback steps for LW, SW, ADDI, BEQ, BNE, R-type and J. It also drives the 4-bit ALU control code directly, decoding funct for R-type. It sits between the instruction register outputs and the datapath mux/enable controls.

Parameters:
FUNCT_W, 6, width of the funct field
RESULT_CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until next FETCH
funct  in  6  IR[5:0]; same stability as opcode
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe; valid with mem_req
i_or_d  out  1  0 selects PC, 1 selects ALUOut as the memory address
ir_write  out  1  load IR
pc_write  out  1  final PC enable (unconditional or branch-qualified)
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 selects PC, 1 selects register A
alu_src_b  out  2  00 regB, 01 constant 4, 10 signext, 11 signext<<2
alu_ctrl  out  4  ALU op: ADD 2, SUB 6, AND 0, OR 1, NOR 12, SLT 7, XOR 13
reg_write  out  1  register file write enable
reg_dst  out  1  1 selects rd, 0 selects rt
mem_to_reg  out  1  1 selects MDR as the writeback source
illegal_instr  out  1  sticky trap flag
state_o  out  4  current state (debug)

Behaviour:
- Moore FSM, 4-bit state. Outputs are decoded from state only, except that pc_write and ir_write in FETCH and pc_write in BRANCH also use their condition inputs.
- While rst_n=0: state=RST; all outputs are 0, including alu_ctrl=0 and state_o=0. On the first clk after release: RST→FETCH.
- FETCH(1): mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut). Next state by opcode: LW/SW→MEMADR, ADD_op(0x00)→EXEC, ADDI→ADDIEX, BEQ/BNE→BRANCH, JMP→JUMP, any other opcode→TRAP.
- MEMADR(3): alu_src_a=1, alu_src_b=10, ADD. Go to MEMRD for LW, MEMWR for SW.
- MEMRD(4): mem_req=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
- MEMWB(5): reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR(6): mem_req=1, mem_we=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXEC(7): alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT. Go to ALUWB. An unlisted funct goes to TRAP instead, and alu_ctrl=ADD in that case.
- ALUWB(8): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- ADDIEX(9): alu_src_a=1, alu_src_b=10, ADD. Go to ADDIWB.
- ADDIWB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH(11): alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write = zero for BEQ, ~zero for BNE. Go to FETCH.
- JUMP(12): pc_src=10, pc_write=1. Go to FETCH.
- TRAP(13): illegal_instr=1, all other outputs 0. Stays in TRAP until rst_n=0; only reset exits.
- Latency with mem_ready tied 1: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted in any state, including mid-memory access, forces RST and zeroes outputs immediately (asynchronous). mem_req drops in the same cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Optional Feature:
MIPS_CTRL_PERF_EN. When defined, two extra outputs are added.
- cycle_cnt[RESULT_CNT_W-1:0]: increments every clk when state≠RST and state≠TRAP.
- instr_cnt[RESULT_CNT_W-1:0]: increments on every transition into FETCH from a non-RST state.
- Both counters are 0 in reset and wrap modulo 2^RESULT_CNT_W.
When undefined, neither port nor counter logic exists and behaviour is otherwise identical.

Test Plan:
- mem_ready=1; opcode 0x00, funct 0x22. Required state sequence FETCH,DECODE,EXEC,ALUWB,FETCH. alu_ctrl=6 in EXEC. In ALUWB: reg_write=1, reg_dst=1.
- LW (0x23) with mem_ready=0 for 2 cycles in MEMRD. MEMRD holds 3 cycles with mem_req=1 and i_or_d=1. Then MEMWB with mem_to_reg=1; total 7 cycles.
- BEQ (0x04) with zero=1 → pc_write=1 and pc_src=01 in BRANCH. BNE (0x05) with zero=1 → pc_write=0. BNE with zero=0 → pc_write=1.
- Illegal opcode 0x3F → DECODE→TRAP; illegal_instr=1 for 20 cycles with no mem_req. Reset, then a valid fetch resumes.
- rst_n driven low mid-MEMWR (mem_ready=0) → all outputs 0 with no clk edge needed. One cycle after release: RST→FETCH.
- MIPS_CTRL_PERF_EN: run ADD, SW, J with mem_ready=1 → instr_cnt=3, cycle_cnt=11 (1 RST→FETCH transition excluded).
